// File: rtl/rv_sdram_bridge_if.sv
// Bus interfaces for rv_sdram_bridge: the CPU-side 32-bit memory bus and the
// 16-bit request port of the SDRAM controller.

interface rv_mem_if;
    logic        mem_valid;
    logic        mem_ready;
    logic [22:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [3:0]  mem_wstrb;
    logic [31:0] mem_rdata;

    modport master (output mem_valid, mem_addr, mem_wdata, mem_wstrb,
                    input  mem_ready, mem_rdata);
    modport slave  (input  mem_valid, mem_addr, mem_wdata, mem_wstrb,
                    output mem_ready, mem_rdata);
endinterface

interface rv_sdram_if;
    logic [21:0] rv_addr;
    logic [15:0] rv_din;
    logic [1:0]  rv_ds;
    logic        rv_rd;
    logic        rv_wr;
    logic        rv_wait;
    logic [15:0] rv_dout;

    modport master (output rv_addr, rv_din, rv_ds, rv_rd, rv_wr,
                    input  rv_wait, rv_dout);
    modport slave  (input  rv_addr, rv_din, rv_ds, rv_rd, rv_wr,
                    output rv_wait, rv_dout);
endinterface

// File: rtl/rv_sdram_bridge.sv
// Splits 32-bit CPU accesses into one or two 16-bit SDRAM controller requests,
// with a one-word write-through read buffer in front of SDRAM.
//
// Handshakes: the CPU holds mem_valid and its address/data until the bridge
// pulses mem_ready for one cycle. Towards SDRAM, rv_rd/rv_wr with rv_addr,
// rv_din and rv_ds are held stable until a rising edge with rv_wait low accepts
// the request; read data is sampled RD_LATENCY edges after that acceptance.

module rv_sdram_bridge #(
    parameter int RD_LATENCY = 2
) (
    input  logic       clk,
    input  logic       resetn,
    input  logic       flush,
    rv_mem_if.slave    mem,
    rv_sdram_if.master rv,
    output logic [2:0] state_dbg
);

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        REQ_LO  = 3'd1,
        WAIT_LO = 3'd2,
        REQ_HI  = 3'd3,
        WAIT_HI = 3'd4,
        DONE    = 3'd5
    } state_t;

    state_t      state;
    logic [3:0]  cnt;
    logic [20:0] tag_q;
    logic [31:0] wdata_q;
    logic [3:0]  wstrb_q;
    logic [15:0] rdata_lo;
    logic        buf_valid;
    logic [20:0] buf_tag;
    logic [31:0] buf_data;
    logic [31:0] merged;
    logic        is_read;
    logic        buf_match;
    logic        unused_addr_bits;

    assign state_dbg        = state;
    assign is_read          = (wstrb_q == 4'b0000);
    assign buf_match        = buf_valid && (buf_tag == tag_q);
    assign unused_addr_bits = ^mem.mem_addr[1:0];

    // Buffer contents after a write-through merge of the current write.
    always_comb begin
        merged = buf_data;
        for (int b = 0; b < 4; b++) begin
            if (wstrb_q[b]) merged[8*b +: 8] = wdata_q[8*b +: 8];
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state         <= IDLE;
            cnt           <= 4'd0;
            tag_q         <= 21'd0;
            wdata_q       <= 32'd0;
            wstrb_q       <= 4'd0;
            rdata_lo      <= 16'd0;
            buf_valid     <= 1'b0;
            buf_tag       <= 21'd0;
            buf_data      <= 32'd0;
            mem.mem_ready <= 1'b0;
            mem.mem_rdata <= 32'd0;
            rv.rv_addr    <= 22'd0;
            rv.rv_din     <= 16'd0;
            rv.rv_ds      <= 2'b00;
            rv.rv_rd      <= 1'b0;
            rv.rv_wr      <= 1'b0;
        end else begin
            mem.mem_ready <= 1'b0;
            case (state)
                IDLE: begin
                    if (mem.mem_valid) begin
                        tag_q   <= mem.mem_addr[22:2];
                        wdata_q <= mem.mem_wdata;
                        wstrb_q <= mem.mem_wstrb;
                        if (mem.mem_wstrb == 4'b0000) begin
                            if (buf_valid && buf_tag == mem.mem_addr[22:2]) begin
                                mem.mem_rdata <= buf_data;
                                mem.mem_ready <= 1'b1;
                                state         <= DONE;
                            end else begin
                                rv.rv_rd   <= 1'b1;
                                rv.rv_addr <= {mem.mem_addr[22:2], 1'b0};
                                rv.rv_ds   <= 2'b11;
                                state      <= REQ_LO;
                            end
                        end else if (mem.mem_wstrb[1:0] != 2'b00) begin
                            rv.rv_wr   <= 1'b1;
                            rv.rv_addr <= {mem.mem_addr[22:2], 1'b0};
                            rv.rv_din  <= mem.mem_wdata[15:0];
                            rv.rv_ds   <= mem.mem_wstrb[1:0];
                            state      <= REQ_LO;
                        end else begin
                            rv.rv_wr   <= 1'b1;
                            rv.rv_addr <= {mem.mem_addr[22:2], 1'b1};
                            rv.rv_din  <= mem.mem_wdata[31:16];
                            rv.rv_ds   <= mem.mem_wstrb[3:2];
                            state      <= REQ_HI;
                        end
                    end
                end
                REQ_LO: begin
                    if (!rv.rv_wait) begin
                        rv.rv_rd <= 1'b0;
                        rv.rv_wr <= 1'b0;
                        if (is_read) begin
                            cnt   <= 4'(RD_LATENCY - 1);
                            state <= WAIT_LO;
                        end else if (wstrb_q[3:2] != 2'b00) begin
                            rv.rv_wr   <= 1'b1;
                            rv.rv_addr <= {tag_q, 1'b1};
                            rv.rv_din  <= wdata_q[31:16];
                            rv.rv_ds   <= wstrb_q[3:2];
                            state      <= REQ_HI;
                        end else begin
                            if (buf_match) buf_data <= merged;
                            mem.mem_ready <= 1'b1;
                            state         <= DONE;
                        end
                    end
                end
                WAIT_LO: begin
                    if (cnt == 4'd0) begin
                        rdata_lo   <= rv.rv_dout;
                        rv.rv_rd   <= 1'b1;
                        rv.rv_addr <= {tag_q, 1'b1};
                        rv.rv_ds   <= 2'b11;
                        state      <= REQ_HI;
                    end else begin
                        cnt <= cnt - 4'd1;
                    end
                end
                REQ_HI: begin
                    if (!rv.rv_wait) begin
                        rv.rv_rd <= 1'b0;
                        rv.rv_wr <= 1'b0;
                        if (is_read) begin
                            cnt   <= 4'(RD_LATENCY - 1);
                            state <= WAIT_HI;
                        end else begin
                            if (buf_match) buf_data <= merged;
                            mem.mem_ready <= 1'b1;
                            state         <= DONE;
                        end
                    end
                end
                WAIT_HI: begin
                    if (cnt == 4'd0) begin
                        mem.mem_rdata <= {rv.rv_dout, rdata_lo};
                        mem.mem_ready <= 1'b1;
                        buf_valid     <= 1'b1;
                        buf_tag       <= tag_q;
                        buf_data      <= {rv.rv_dout, rdata_lo};
                        state         <= DONE;
                    end else begin
                        cnt <= cnt - 4'd1;
                    end
                end
                DONE:    state <= IDLE;
                default: state <= IDLE;
            endcase
            // Flush takes priority over a fill or merge on the same edge.
            if (flush) buf_valid <= 1'b0;
        end
    end

endmodule

// File: tb/tb_rv_sdram_bridge.sv
// Scoreboarded bench for rv_sdram_bridge: directed CPU accesses against a
// small SDRAM model, with completion data and latency checked by a monitor.

module tb_rv_sdram_bridge;

    localparam int L = 2;

    logic clk;
    logic resetn;
    logic flush;
    logic [2:0] state_dbg;

    rv_mem_if   mem_bus ();
    rv_sdram_if rv_bus ();

    rv_sdram_bridge #(.RD_LATENCY(L)) dut (
        .clk       (clk),
        .resetn    (resetn),
        .flush     (flush),
        .mem       (mem_bus),
        .rv        (rv_bus),
        .state_dbg (state_dbg)
    );

    int n_tests = 0;
    int n_fail  = 0;
    int cyc     = 0;
    int start_cyc = 0;

    logic [31:0] exp_q[$];
    int          lat_q[$];

    logic [15:0] sdram [0:511];
    int          rd_due_q[$];
    logic [21:0] rd_src_q[$];
    logic [21:0] rd_log[$];
    logic [21:0] wr_addr_log[$];
    logic [15:0] wr_din_log[$];
    logic [1:0]  wr_ds_log[$];
    int          wr_cycles = 0;

    // ---------------- clock / reset ----------------
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial forever begin
        @(posedge clk);
        cyc++;
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // ---------------- SDRAM model ----------------
    initial forever begin
        @(negedge clk);
        #1;
        if (!resetn) begin
            rd_due_q.delete();
            rd_src_q.delete();
            rv_bus.rv_dout = 16'hDEAD;
        end else begin
            if (rv_bus.rv_rd && !rv_bus.rv_wait) begin
                rd_due_q.push_back(cyc + 1 + L);
                rd_src_q.push_back(rv_bus.rv_addr);
                rd_log.push_back(rv_bus.rv_addr);
            end
            if (rv_bus.rv_wr) wr_cycles++;
            if (rv_bus.rv_wr && !rv_bus.rv_wait) begin
                if (rv_bus.rv_ds[0]) sdram[rv_bus.rv_addr[8:0]][7:0]  = rv_bus.rv_din[7:0];
                if (rv_bus.rv_ds[1]) sdram[rv_bus.rv_addr[8:0]][15:8] = rv_bus.rv_din[15:8];
                wr_addr_log.push_back(rv_bus.rv_addr);
                wr_din_log.push_back(rv_bus.rv_din);
                wr_ds_log.push_back(rv_bus.rv_ds);
            end
            if (rd_due_q.size() > 0 && rd_due_q[0] == cyc + 1) begin
                rv_bus.rv_dout = sdram[rd_src_q[0][8:0]];
                void'(rd_due_q.pop_front());
                void'(rd_src_q.pop_front());
            end else begin
                rv_bus.rv_dout = 16'hDEAD;
            end
        end
    end

    // ---------------- monitor / scoreboard ----------------
    initial forever begin
        @(negedge clk);
        if (rv_bus.rv_rd && rv_bus.rv_wr) check("rd_wr_exclusive", 32'd1, 32'd0);
        if (mem_bus.mem_ready) begin
            if (exp_q.size() == 0) begin
                check("unexpected_ready", 32'd1, 32'd0);
            end else begin
                check("rdata", mem_bus.mem_rdata, exp_q.pop_front());
                check("latency", 32'(cyc - start_cyc), 32'(lat_q.pop_front()));
            end
        end
    end

    // ---------------- driver tasks ----------------
    task automatic do_access(input logic [22:0] addr, input logic [31:0] wdata,
                             input logic [3:0] wstrb, input logic [31:0] exp_rdata,
                             input int exp_lat, input int n_wait, input int flush_at,
                             input int exp_rd, input int exp_wr);
        int  waits_left;
        int  rd_base;
        int  wr_base;
        bit  got;
        @(posedge clk);
        #1;
        start_cyc = cyc;
        rd_base   = rd_log.size();
        wr_base   = wr_addr_log.size();
        exp_q.push_back(exp_rdata);
        lat_q.push_back(exp_lat);
        mem_bus.mem_valid = 1'b1;
        mem_bus.mem_addr  = addr;
        mem_bus.mem_wdata = wdata;
        mem_bus.mem_wstrb = wstrb;
        waits_left = n_wait;
        got = 1'b0;
        for (int i = 0; i < 100 && !got; i++) begin
            @(negedge clk);
            if (flush_at >= 0 && cyc - start_cyc == flush_at) flush = 1'b1;
            rv_bus.rv_wait = (waits_left > 0) && (rv_bus.rv_rd || rv_bus.rv_wr);
            if (rv_bus.rv_wait) waits_left--;
            if (mem_bus.mem_ready) got = 1'b1;
        end
        if (!got) begin
            check("ready_timeout", 32'd0, 32'd1);
            void'(exp_q.pop_back());
            void'(lat_q.pop_back());
        end
        @(posedge clk);
        #1;
        mem_bus.mem_valid = 1'b0;
        flush = 1'b0;
        rv_bus.rv_wait = 1'b0;
        #1;
        check("rd_requests", 32'(rd_log.size() - rd_base), 32'(exp_rd));
        check("wr_requests", 32'(wr_addr_log.size() - wr_base), 32'(exp_wr));
    endtask

    task automatic pulse_flush();
        @(posedge clk);
        #1 flush = 1'b1;
        @(posedge clk);
        #1 flush = 1'b0;
    endtask

    // ---------------- stimulus ----------------
    initial begin
        int  rd_base;
        int  wc_base;
        bit  got;
        resetn = 1'b0;
        flush  = 1'b0;
        mem_bus.mem_valid = 1'b0;
        mem_bus.mem_addr  = 23'd0;
        mem_bus.mem_wdata = 32'd0;
        mem_bus.mem_wstrb = 4'd0;
        rv_bus.rv_wait    = 1'b0;
        rv_bus.rv_dout    = 16'hDEAD;
        for (int i = 0; i < 512; i++) sdram[i] = 16'h0000;
        sdram[9'h080] = 16'hBBBB;
        sdram[9'h081] = 16'hAAAA;
        sdram[9'h100] = 16'h5555;
        sdram[9'h101] = 16'h6666;

        repeat (3) @(negedge clk);
        check("rst_mem_ready", {31'd0, mem_bus.mem_ready}, 32'd0);
        check("rst_rv_rd", {31'd0, rv_bus.rv_rd}, 32'd0);
        check("rst_rv_wr", {31'd0, rv_bus.rv_wr}, 32'd0);
        check("rst_mem_rdata", mem_bus.mem_rdata, 32'd0);
        check("rst_rv_addr", {10'd0, rv_bus.rv_addr}, 32'd0);
        check("rst_rv_din", {16'd0, rv_bus.rv_din}, 32'd0);
        check("rst_rv_ds", {30'd0, rv_bus.rv_ds}, 32'd0);
        check("rst_state", {29'd0, state_dbg}, 32'd0);
        resetn = 1'b1;

        // Read miss, then hit, then flush and miss again.
        rd_base = rd_log.size();
        do_access(23'h000100, 32'd0, 4'b0000, 32'hAAAABBBB, 7, 0, -1, 2, 0);
        check("miss_addr_lo", {10'd0, rd_log[rd_base]}, 32'h80);
        check("miss_addr_hi", {10'd0, rd_log[rd_base+1]}, 32'h81);
        do_access(23'h000100, 32'd0, 4'b0000, 32'hAAAABBBB, 1, 0, -1, 0, 0);
        pulse_flush();
        do_access(23'h000100, 32'd0, 4'b0000, 32'hAAAABBBB, 7, 0, -1, 2, 0);

        // Upper-half write merges into the buffer; mem_rdata holds.
        do_access(23'h000100, 32'h12345678, 4'b1100, 32'hAAAABBBB, 2, 0, -1, 0, 1);
        check("w_hi_addr", {10'd0, wr_addr_log[wr_addr_log.size()-1]}, 32'h81);
        check("w_hi_din", {16'd0, wr_din_log[wr_din_log.size()-1]}, 32'h1234);
        check("w_hi_ds", {30'd0, wr_ds_log[wr_ds_log.size()-1]}, 32'h3);
        check("w_hi_sdram", {16'd0, sdram[9'h081]}, 32'h1234);
        do_access(23'h000100, 32'd0, 4'b0000, 32'h1234BBBB, 1, 0, -1, 0, 0);

        // Single byte write stalled by rv_wait for three cycles.
        wc_base = wr_cycles;
        do_access(23'h000200, 32'h000000EE, 4'b0001, 32'h1234BBBB, 5, 3, -1, 0, 1);
        check("w_wait_cycles", 32'(wr_cycles - wc_base), 32'd4);
        check("w_wait_ds", {30'd0, wr_ds_log[wr_ds_log.size()-1]}, 32'h1);
        check("w_wait_addr", {10'd0, wr_addr_log[wr_addr_log.size()-1]}, 32'h100);
        check("w_wait_sdram", {16'd0, sdram[9'h100]}, 32'h55EE);

        // Full write to the buffered word, then a hit returns the new word.
        do_access(23'h000100, 32'hCAFEF00D, 4'b1111, 32'h1234BBBB, 3, 0, -1, 0, 2);
        do_access(23'h000100, 32'd0, 4'b0000, 32'hCAFEF00D, 1, 0, -1, 0, 0);

        // Reset while the second read half is in flight.
        @(posedge clk);
        #1;
        start_cyc = cyc;
        mem_bus.mem_valid = 1'b1;
        mem_bus.mem_addr  = 23'h000200;
        mem_bus.mem_wstrb = 4'b0000;
        got = 1'b0;
        for (int i = 0; i < 40 && !got; i++) begin
            @(negedge clk);
            if (state_dbg == 3'd4) got = 1'b1;
        end
        check("reach_wait_hi", {31'd0, got}, 32'd1);
        resetn = 1'b0;
        mem_bus.mem_valid = 1'b0;
        #1;
        check("ar_rv_rd", {31'd0, rv_bus.rv_rd}, 32'd0);
        check("ar_rv_addr", {10'd0, rv_bus.rv_addr}, 32'd0);
        check("ar_mem_rdata", mem_bus.mem_rdata, 32'd0);
        check("ar_mem_ready", {31'd0, mem_bus.mem_ready}, 32'd0);
        check("ar_state", {29'd0, state_dbg}, 32'd0);
        repeat (2) @(negedge clk);
        resetn = 1'b1;
        repeat (3) @(negedge clk);
        do_access(23'h000100, 32'd0, 4'b0000, 32'hCAFEF00D, 7, 0, -1, 2, 0);
        do_access(23'h000200, 32'd0, 4'b0000, 32'h666655EE, 7, 0, -1, 2, 0);

        // Flush across the completing read miss leaves the buffer empty.
        do_access(23'h000100, 32'd0, 4'b0000, 32'hCAFEF00D, 7, 0, 6, 2, 0);
        do_access(23'h000100, 32'd0, 4'b0000, 32'hCAFEF00D, 7, 0, -1, 2, 0);

        repeat (4) @(negedge clk);
        check("exp_q_drained", 32'(exp_q.size()), 32'd0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
